// File: rtl/twos_comp_serial_ctrl.sv
// Word-level sequencer for a bit-serial two's-complement converter: accepts a word,
// clears the converter, streams the word LSB-first and captures the serial result.
module twos_comp_serial_ctrl #(
  parameter int WIDTH = 8,
  parameter int LAT   = 0
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy,
  output logic             ser_i,
  output logic             ser_r,
  input  logic             ser_y
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SHIFT, S_DRAIN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_shift, r_cap, r_out_data;
  logic [CW-1:0]    r_cnt, r_cap_cnt;
  logic             r_ovf;
  logic             w_accept, w_last, w_capture;
  logic [WIDTH-1:0] w_cap_next;

  // Reset is also folded in combinationally so in_ready drops and the converter
  // is cleared the instant r rises, not at the next edge.
  assign in_ready  = (r_state == S_IDLE) && !r;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_out_data;
  assign out_ovf   = r_ovf;
  assign ser_r     = r || (r_state == S_CLEAR);
  assign ser_i     = (r_state == S_SHIFT) ? r_shift[0] : 1'b0;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  // With a registered converter the first SHIFT cycle still shows the cleared output.
  assign w_capture = (((r_state == S_SHIFT) && ((LAT == 0) || (r_cnt != '0))) ||
                      (r_state == S_DRAIN)) && (r_cap_cnt < CW'(WIDTH));
  assign w_cap_next = w_capture ? {ser_y, r_cap[WIDTH-1:1]} : r_cap;

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CLEAR;
      S_CLEAR: w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = (LAT == 1) ? S_DRAIN : S_DONE;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_cap      <= '0;
      r_out_data <= '0;
      r_cnt      <= '0;
      r_cap_cnt  <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_accept) begin
        r_shift   <= in_data;
        r_ovf     <= (in_data == MIN_NEG);
        r_cnt     <= '0;
        r_cap_cnt <= '0;
        r_cap     <= '0;
      end
      if (r_state == S_SHIFT) begin
        r_shift <= r_shift >> 1;
        r_cnt   <= r_cnt + CW'(1);
      end
      if (w_capture) begin
        r_cap     <= w_cap_next;
        r_cap_cnt <= r_cap_cnt + CW'(1);
      end
      // The final bit is captured on the same edge that enters DONE.
      if (w_next == S_DONE && r_state != S_DONE) r_out_data <= w_cap_next;
    end
  end

endmodule

// File: tb/tb_twos_comp_serial_ctrl.sv
// Directed bench: one controller with a Mealy converter model (LAT=0) and one with
// a registered converter model (LAT=1), both WIDTH=8.
module tb_twos_comp_serial_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf, a_busy;
  logic       a_ser_i, a_ser_r, a_ser_y;
  logic [7:0] a_in_data, a_out_data;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf, b_busy;
  logic       b_ser_i, b_ser_r, b_ser_y;
  logic [7:0] b_in_data, b_out_data;

  twos_comp_serial_ctrl #(.WIDTH(8), .LAT(0)) dut_a (
    .t_clk(clk), .r(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ovf(a_out_ovf),
    .busy(a_busy), .ser_i(a_ser_i), .ser_r(a_ser_r), .ser_y(a_ser_y));

  twos_comp_serial_ctrl #(.WIDTH(8), .LAT(1)) dut_b (
    .t_clk(clk), .r(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ovf(b_out_ovf),
    .busy(b_busy), .ser_i(b_ser_i), .ser_r(b_ser_r), .ser_y(b_ser_y));

  // Behavioural converters: pass bits through until the first 1, invert afterwards.
  logic a_seen, b_seen, b_y_q;
  always @(posedge clk) begin
    if (a_ser_r) a_seen <= 1'b0; else if (a_ser_i) a_seen <= 1'b1;
    if (b_ser_r) begin
      b_seen <= 1'b0;
      b_y_q  <= 1'b0;
    end else begin
      if (b_ser_i) b_seen <= 1'b1;
      b_y_q <= b_seen ? ~b_ser_i : b_ser_i;
    end
  end
  assign a_ser_y = a_seen ? ~a_ser_i : a_ser_i;
  assign b_ser_y = b_y_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one word through the selected controller and reports what was observed.
  task automatic xfer(input bit sel, input logic [7:0] d, output int lat, output logic [7:0] q,
                      output logic ovf, output int clr_n, output int run_n, output logic [7:0] sbits);
    int si;
    logic srr, bsy, sdi, vld;
    if (sel) begin b_in_valid = 1'b1; b_in_data = d; end
    else     begin a_in_valid = 1'b1; a_in_data = d; end
    tick();
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    lat = -1; clr_n = 0; run_n = 0; si = 0; sbits = '0;
    for (int k = 1; k <= 40; k++) begin
      srr = sel ? b_ser_r : a_ser_r;
      bsy = sel ? b_busy : a_busy;
      sdi = sel ? b_ser_i : a_ser_i;
      if (srr) clr_n++;
      else if (bsy) begin
        run_n++;
        if (si < 8) sbits[si] = sdi;
        si++;
      end
      tick();
      vld = sel ? b_out_valid : a_out_valid;
      if (vld) begin lat = k; break; end
    end
    q   = sel ? b_out_data : a_out_data;
    ovf = sel ? b_out_ovf : a_out_ovf;
    if (sel) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0; b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", a_out_valid); end
    checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %h exp 00", a_out_data); end
    checks++; if (a_out_ovf !== 1'b0) begin errors++; $display("FAIL rst_out_ovf got %b exp 0", a_out_ovf); end
    checks++; if (a_busy !== 1'b0 || a_ser_i !== 1'b0) begin errors++; $display("FAIL rst_busy_ser_i got %b%b exp 00", a_busy, a_ser_i); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", a_in_ready); end
    checks++; if (a_ser_r !== 1'b1 || b_ser_r !== 1'b1) begin errors++; $display("FAIL rst_ser_r got %b%b exp 11", a_ser_r, b_ser_r); end
    rst = 1'b0;
    tick();
    checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b%b exp 11", a_in_ready, b_in_ready); end
    checks++; if (a_ser_r !== 1'b0) begin errors++; $display("FAIL rel_ser_r got %b exp 0", a_ser_r); end
  endtask

  task automatic test_basic();
    int lat, clr_n, run_n;
    logic [7:0] q, sb;
    logic ovf;
    xfer(1'b0, 8'h01, lat, q, ovf, clr_n, run_n, sb);
    checks++; if (q !== 8'hFF || ovf !== 1'b0) begin errors++; $display("FAIL w01_result got %h/%b exp FF/0", q, ovf); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL w01_latency got %0d exp 9", lat); end
    checks++; if (clr_n !== 1) begin errors++; $display("FAIL w01_clear_cycles got %0d exp 1", clr_n); end
    checks++; if (sb !== 8'h01 || run_n !== 8) begin errors++; $display("FAIL w01_serial got %h/%0d exp 01/8", sb, run_n); end
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("FAIL w01_release got %b%b exp 01", a_out_valid, a_in_ready); end
    xfer(1'b0, 8'h80, lat, q, ovf, clr_n, run_n, sb);
    checks++; if (q !== 8'h80 || ovf !== 1'b1) begin errors++; $display("FAIL w80_result got %h/%b exp 80/1", q, ovf); end
    xfer(1'b0, 8'h00, lat, q, ovf, clr_n, run_n, sb);
    checks++; if (q !== 8'h00 || ovf !== 1'b0) begin errors++; $display("FAIL w00_result got %h/%b exp 00/0", q, ovf); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL w00_latency got %0d exp 9", lat); end
  endtask

  task automatic test_hold();
    int n;
    a_in_valid = 1'b1; a_in_data = 8'h3C;
    tick();
    a_in_valid = 1'b0;
    n = 0;
    while (!a_out_valid && n < 40) begin tick(); n++; end
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL hold_timeout got %b exp 1", a_out_valid); end
    for (int c = 0; c < 5; c++) begin
      a_in_valid = c[0] ? 1'b0 : 1'b1;
      a_in_data  = 8'h11;
      tick();
      checks++;
      if (a_out_data !== 8'hC4 || a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d got data %h vld %b rdy %b exp C4 1 0", c, a_out_data, a_out_valid, a_in_ready);
      end
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin errors++; $display("FAIL hold_release got rdy %b vld %b exp 1 0", a_in_ready, a_out_valid); end
    tick();
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL hold_no_ghost_word got busy %b exp 0", a_busy); end
  endtask

  task automatic test_reset_mid();
    int lat, clr_n, run_n, seen;
    logic [7:0] q, sb;
    logic ovf;
    a_in_valid = 1'b1; a_in_data = 8'hF0;
    tick();
    a_in_valid = 1'b0;
    repeat (5) tick();
    checks++; if (a_busy !== 1'b1 || a_ser_r !== 1'b0) begin errors++; $display("FAIL mid_pre_state got busy %b ser_r %b exp 1 0", a_busy, a_ser_r); end
    rst = 1'b1;
    #1;
    checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0 || a_ser_r !== 1'b1 || a_in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset got vld %b busy %b ser_r %b rdy %b exp 0 0 1 0", a_out_valid, a_busy, a_ser_r, a_in_ready);
    end
    tick(); tick();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 15; c++) begin tick(); if (a_out_valid || a_busy) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_aborted got %0d active cycles exp 0", seen); end
    xfer(1'b0, 8'h5A, lat, q, ovf, clr_n, run_n, sb);
    checks++; if (q !== 8'hA6 || ovf !== 1'b0) begin errors++; $display("FAIL mid_after_5A got %h/%b exp A6/0", q, ovf); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [3];
    logic [7:0] e [3];
    logic [7:0] res [3];
    int acc [3];
    int idx, ridx, cyc;
    w[0] = 8'h01; w[1] = 8'h7F; w[2] = 8'hFF;
    e[0] = 8'hFF; e[1] = 8'h81; e[2] = 8'h01;
    idx = 0; ridx = 0; cyc = 0;
    for (int i = 0; i < 3; i++) begin res[i] = 'x; acc[i] = -100; end
    a_out_ready = 1'b1;
    while (ridx < 3 && cyc < 100) begin
      if (a_out_valid) begin res[ridx] = a_out_data; ridx++; end
      if (a_in_ready && idx < 3) begin
        a_in_valid = 1'b1; a_in_data = w[idx]; acc[idx] = cyc; idx++;
      end else a_in_valid = 1'b0;
      tick();
      cyc++;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (res[i] !== e[i]) begin errors++; $display("FAIL b2b_result%0d got %h exp %h", i, res[i], e[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      checks++; if (acc[i] - acc[i-1] !== 11) begin errors++; $display("FAIL b2b_interval%0d got %0d exp 11", i, acc[i] - acc[i-1]); end
    end
  endtask

  task automatic test_lat1();
    int lat, clr_n, run_n;
    logic [7:0] q, sb;
    logic ovf;
    xfer(1'b1, 8'h06, lat, q, ovf, clr_n, run_n, sb);
    checks++; if (q !== 8'hFA || ovf !== 1'b0) begin errors++; $display("FAIL lat1_result got %h/%b exp FA/0", q, ovf); end
    checks++; if (lat !== 10) begin errors++; $display("FAIL lat1_latency got %0d exp 10", lat); end
    checks++; if (clr_n !== 1) begin errors++; $display("FAIL lat1_clear_cycles got %0d exp 1", clr_n); end
    // 8 SHIFT cycles plus exactly one DRAIN cycle.
    checks++; if (run_n !== 9 || sb !== 8'h06) begin errors++; $display("FAIL lat1_shift_drain got %0d/%h exp 9/06", run_n, sb); end
    xfer(1'b1, 8'h80, lat, q, ovf, clr_n, run_n, sb);
    checks++; if (q !== 8'h80 || ovf !== 1'b1) begin errors++; $display("FAIL lat1_w80 got %h/%b exp 80/1", q, ovf); end
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    repeat (3) tick();
    test_reset();
    test_basic();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_lat1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/twos_comp_serial_ctrl.md
Name: twos_comp_serial_ctrl

Overview:
Word-level sequencer for the bit-serial two's-complement converter (serial in, active-high clear, serial out).
- Accepts a parallel WIDTH-bit word over a valid/ready handshake.
- Clears the converter, streams the word LSB-first into it and captures the serial result back into a word.
- Presents the result with an overflow flag over a second valid/ready handshake.
- Sits between the parallel datapath and one converter instance. It owns that converter's serial input and clear lines.

Parameters:
WIDTH, 8, word width in bits (>=2)
LAT, 0, converter latency in clocks from ser_i to matching ser_y (0 = Mealy output, 1 = registered output); only 0 or 1 legal

Ports:
t_clk  input  1  clock, all state updates on rising edge
r  input  1  reset, asynchronous, active-high
in_valid  input  1  input word valid
in_ready  output  1  controller can accept a word
in_data  input  WIDTH  word to negate
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  two's complement of accepted word
out_ovf  output  1  input was the most negative value (only MSB set), so the result equals the input
busy  output  1  state is not IDLE
ser_i  output  1  serial bit to converter
ser_r  output  1  converter clear, active-high
ser_y  input  1  serial result bit from converter

Behaviour:
- Reset (r=1, asynchronous):
  - state=IDLE; shift, capture and bit counters zeroed; out_valid=0, out_data=0, out_ovf=0.
  - ser_i=0, busy=0.
  - in_ready=0 while r=1; in_ready=1 on the first cycle after release.
- ser_r = r OR (state==CLEAR), combinational. The converter is held clear throughout reset.
- State IDLE:
  - in_ready=1.
  - in_valid&in_ready at an edge: load in_data into the shift register, latch ovf = (in_data == 1<<(WIDTH-1)), cnt=0, go to CLEAR.
- State CLEAR:
  - Lasts exactly 1 cycle; ser_r=1, ser_i=0.
  - Goes to SHIFT.
- State SHIFT:
  - ser_i = shift[0]. At each edge the shift register shifts right and cnt increments.
  - Capture register shifts right with ser_y entering the MSB on edges where the captured-bit count is below WIDTH and the cycle index within SHIFT is >= LAT.
  - After the edge with cnt==WIDTH-1: go to DRAIN if LAT=1, otherwise go to DONE.
- State DRAIN (LAT=1 only):
  - Lasts 1 cycle; ser_i=0; captures the final bit.
  - Goes to DONE.
- State DONE:
  - out_valid=1; out_data and out_ovf are held stable until accepted.
  - out_valid&out_ready at an edge: go to IDLE and clear out_valid.
  - out_data retains its last value; it is don't-care when out_valid=0.
- Handshake rules:
  - in_ready=0 in every state except IDLE; in_valid is ignored there and no word is lost or queued.
  - Single word in flight; no overlap between output hold and the next accept.
- Latency: out_valid rises 1+WIDTH+LAT rising edges after the accepting edge. Minimum issue interval is 3+WIDTH+LAT cycles with out_ready tied high.
- Arithmetic: out_data = (~in_data + 1) mod 2^WIDTH, as produced by the converter; the controller does not recompute it.
  - Zero input gives zero output with ovf=0.
  - 1<<(WIDTH-1) gives itself with ovf=1.
- Reset mid-operation, in any state: the word is aborted, no out_valid is produced, and the converter is cleared via ser_r.
- out_ready held high while not in DONE has no effect.

Test Plan:
WIDTH=8, LAT=0, with a behavioural converter:
- Accept 8'h01 -> out_data=8'hFF, out_ovf=0, out_valid rises 9 edges after accept; ser_r high for exactly 1 cycle before bit 0.
- Accept 8'h80 -> out_data=8'h80, out_ovf=1. Then accept 8'h00 -> out_data=8'h00, out_ovf=0.
- Accept 8'h3C, hold out_ready=0 for 5 cycles while pulsing in_valid with 8'h11 -> out_data stays 8'hC4, out_valid stays 1, in_ready stays 0, 8'h11 never processed; release out_ready -> in_ready=1 on the next cycle.
- Assert r mid-SHIFT after 4 bits -> out_valid=0, busy=0, ser_r=1 immediately; after release accept 8'h5A -> out_data=8'hA6, ovf=0.
- Back-to-back stream 8'h01, 8'h7F, 8'hFF with out_ready=1 -> results 8'hFF, 8'h81, 8'h01, each accept 11 cycles apart.
- LAT=1, registered converter: accept 8'h06 -> out_data=8'hFA, out_valid rises 10 edges after accept, DRAIN entered for exactly 1 cycle.
